id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  input  1  asynchronous active-high reset.
REQ-003 SHALL have ports: ID_Valid  input  1  decode slot holds a real instruction.
REQ-004 SHALL have ports: ID_Rs, ID_Rt, ID_Rd  input  5 each  decoded register numbers.
REQ-005 SHALL have ports: ID_UsesRt  input  1  instruction reads Rt as a source operand.
REQ-006 SHALL have ports: ID_ReadData1, ID_ReadData2, ID_SignExt  input  32 each  operand and immediate values.
REQ-007 SHALL have ports: ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegDst, ID_ALUSrc  input  1 each  control bits.
REQ-008 SHALL have ports: ID_ALUOp  input  3  ALU operation code.
REQ-009 SHALL have ports: Flush  input  1  branch or jump resolved taken; squash the decode slot.
REQ-010 SHALL have ports: IDEX_* outputs mirroring every ID_* input above (same widths, excluding ID_UsesRt), plus IDEX_Valid  output  1.
REQ-011 SHALL have ports: Stall  output  1  combinational; holds PC and the IF/ID register this cycle.
REQ-012 SHALL have ports: StallCount  output  16  load-use stall cycles; present only under the configuration macro.

Function
REQ-013 SHALL register all ID_* fields into IDEX_* on each rising clk edge; latency is exactly one cycle.
REQ-014 SHALL assert Stall (load-use) when IDEX_Valid & IDEX_MemRead & IDEX_Rt!=0 & ID_Valid & (IDEX_Rt==ID_Rs | (ID_UsesRt & IDEX_Rt==ID_Rt)).
REQ-015 SHALL, on a Stall cycle, load a bubble: IDEX_Valid=0, every control bit and IDEX_ALUOp=0, and IDEX_Rs/Rt/Rd=0, so downstream forwarding never matches the bubble.
REQ-016 SHALL keep bubble data fields (ReadData1/2, SignExt) at 0 for determinism.
REQ-017 SHALL let Flush override Stall: with Flush=1, Stall=0 and a bubble is loaded.
REQ-018 SHALL assert Stall for exactly one cycle per load-use pair; the stall cannot self-repeat because the bubble clears IDEX_MemRead.
REQ-019 SHALL load a bubble when ID_Valid=0, regardless of the other ID_* values.
REQ-020 SHALL treat register 0 as never hazardous, whatever MemRead is.

Reset
REQ-021 SHALL, while reset=1, asynchronously force all IDEX_* outputs (IDEX_Valid included) and StallCount to 0.
REQ-022 SHALL hold Stall=0 while reset=1.
REQ-023 SHALL, on reset deassertion mid-stream, load the first post-reset cycle from ID_* normally.

Configuration
REQ-024 SHALL, with STALL_COUNTER_EN defined, provide StallCount, which increments by 1 on each clock edge where Stall=1 and saturates at 16'hFFFF.
REQ-025 SHALL, without STALL_COUNTER_EN, omit the StallCount port and counter entirely, leaving all other behaviour identical.

Structure
REQ-026 SHALL take ALUOp width (3), register-number width (5), data width (32), the zero register constant and the bubble control value from the shared package pipeline_pkg.
REQ-027 SHALL place the REQ-014 comparison in one combinational sub-module, load_use_detect; the pipeline register and counter stay in id_ex_stage.

Verification
REQ-028 SHALL cover load-use on Rs: lw $8 in EX (IDEX_MemRead=1, IDEX_Rt=8), add using ID_Rs=8 -> Stall=1 for one cycle, next IDEX_Valid=0, then add enters EX with Stall=0.
REQ-029 SHALL cover the ID_UsesRt gate: IDEX_Rt=9 load, ID_Rt=9 with ID_UsesRt=0 -> Stall=0; same with ID_UsesRt=1 -> Stall=1.
REQ-030 SHALL cover the zero register: load with IDEX_Rt=0 and ID_Rs=0 -> Stall=0.
REQ-031 SHALL cover Flush priority: Flush=1 in the same cycle as a load-use match -> Stall=0, IDEX_Valid=0, all control bits 0.
REQ-032 SHALL cover async reset: assert reset between clock edges with IDEX_RegWrite=1 -> IDEX_RegWrite=0 immediately, without waiting for clk.
REQ-033 SHALL cover the counter under STALL_COUNTER_EN: 3 separate load-use events -> StallCount=3; preload at 16'hFFFF plus one more stall -> stays 16'hFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: field widths, the zero register and the
// control bundle carried from decode to execute, including the bubble value.
package pipeline_pkg;

  localparam int ALUOP_W = 3;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  // Control bits travelling with an instruction into EX.
  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  // A bubble does nothing: no write, no memory access, ALU op 0.
  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags when the load sitting in EX writes a
// register the instruction in decode needs. Register 0 is never a hazard.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hazard
);

  logic rs_match;
  logic rt_match;

  // Rt only matters when the decoded instruction reads it as a source.
  always_comb begin
    rs_match = (ex_rt == id_rs);
    rt_match = id_uses_rt && (ex_rt == id_rt);
    hazard   = ex_valid && ex_mem_read && (ex_rt != ZERO_REG) &&
               id_valid && (rs_match || rt_match);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation.
// A cycle loads a bubble (all fields zero, IDEX_Valid=0) when the decode
// slot is squashed by Flush, stalled by a load-use hazard, or empty.
// Flush wins over Stall: a squashed instruction cannot cause a stall.
// Optional feature: define STALL_COUNTER_EN to add the saturating
// StallCount output counting load-use stall cycles.
module id_ex_stage
  import pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               ID_Valid,
  input  logic [REG_W-1:0]   ID_Rs,
  input  logic [REG_W-1:0]   ID_Rt,
  input  logic [REG_W-1:0]   ID_Rd,
  input  logic               ID_UsesRt,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_SignExt,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemtoReg,
  input  logic               ID_RegDst,
  input  logic               ID_ALUSrc,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic               Flush,
  output logic               IDEX_Valid,
  output logic [REG_W-1:0]   IDEX_Rs,
  output logic [REG_W-1:0]   IDEX_Rt,
  output logic [REG_W-1:0]   IDEX_Rd,
  output logic [DATA_W-1:0]  IDEX_ReadData1,
  output logic [DATA_W-1:0]  IDEX_ReadData2,
  output logic [DATA_W-1:0]  IDEX_SignExt,
  output logic               IDEX_RegWrite,
  output logic               IDEX_MemRead,
  output logic               IDEX_MemWrite,
  output logic               IDEX_MemtoReg,
  output logic               IDEX_RegDst,
  output logic               IDEX_ALUSrc,
  output logic [ALUOP_W-1:0] IDEX_ALUOp,
`ifdef STALL_COUNTER_EN
  output logic [15:0]        StallCount,
`endif
  output logic               Stall
);

  logic  hazard;
  logic  bubble;
  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;

  load_use_detect u_detect (
    .ex_valid    (IDEX_Valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rt       (IDEX_Rt),
    .id_valid    (ID_Valid),
    .id_rs       (ID_Rs),
    .id_rt       (ID_Rt),
    .id_uses_rt  (ID_UsesRt),
    .hazard      (hazard)
  );

  // Stall is suppressed by Flush (squashed slot) and by reset.
  always_comb begin
    Stall  = hazard && !Flush && !reset;
    bubble = Flush || hazard || !ID_Valid;
    id_ctrl = '{reg_write:  ID_RegWrite,
                mem_read:   ID_MemRead,
                mem_write:  ID_MemWrite,
                mem_to_reg: ID_MemtoReg,
                reg_dst:    ID_RegDst,
                alu_src:    ID_ALUSrc,
                alu_op:     ID_ALUOp};
  end

  // Pipeline register: capture decode fields or a fully zeroed bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IDEX_Valid     <= 1'b0;
      IDEX_Rs        <= ZERO_REG;
      IDEX_Rt        <= ZERO_REG;
      IDEX_Rd        <= ZERO_REG;
      IDEX_ReadData1 <= '0;
      IDEX_ReadData2 <= '0;
      IDEX_SignExt   <= '0;
      ex_ctrl        <= BUBBLE_CTRL;
    end else if (bubble) begin
      IDEX_Valid     <= 1'b0;
      IDEX_Rs        <= ZERO_REG;
      IDEX_Rt        <= ZERO_REG;
      IDEX_Rd        <= ZERO_REG;
      IDEX_ReadData1 <= '0;
      IDEX_ReadData2 <= '0;
      IDEX_SignExt   <= '0;
      ex_ctrl        <= BUBBLE_CTRL;
    end else begin
      IDEX_Valid     <= 1'b1;
      IDEX_Rs        <= ID_Rs;
      IDEX_Rt        <= ID_Rt;
      IDEX_Rd        <= ID_Rd;
      IDEX_ReadData1 <= ID_ReadData1;
      IDEX_ReadData2 <= ID_ReadData2;
      IDEX_SignExt   <= ID_SignExt;
      ex_ctrl        <= id_ctrl;
    end
  end

  // Unpack the registered control bundle onto the named outputs.
  always_comb begin
    IDEX_RegWrite = ex_ctrl.reg_write;
    IDEX_MemRead  = ex_ctrl.mem_read;
    IDEX_MemWrite = ex_ctrl.mem_write;
    IDEX_MemtoReg = ex_ctrl.mem_to_reg;
    IDEX_RegDst   = ex_ctrl.reg_dst;
    IDEX_ALUSrc   = ex_ctrl.alu_src;
    IDEX_ALUOp    = ex_ctrl.alu_op;
  end

`ifdef STALL_COUNTER_EN
  logic [15:0] stall_count_q;

  // Count load-use stall cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= 16'h0000;
    end else if (Stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_q <= stall_count_q + 16'h0001;
    end
  end

  assign StallCount = stall_count_q;
`endif

endmodule
